// File: rtl/alu_pkg.sv
// Shared constants for the shift sequencer: shift direction codes and FSM state encoding.
package alu_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter; the vacated bit is taken from i_fill.
module shift_step
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_dir,
    input  logic         i_fill,
    input  logic [N-1:0] i_a,
    output logic [N-1:0] o_y
);

    assign o_y = (i_dir == DIR_RIGHT) ? {i_fill, i_a[N-1:1]} : {i_a[N-2:0], i_fill};

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one bit position per clock, with a valid/ready request and result handshake.
// Optional build macro SHIFT_ARITH_EN adds in_arith (sign fill on right shifts).
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | waiting for a request, in_ready high
//   SHIFT    | shifting one bit per edge, r_cnt positions left
//   DONE     | result held on out_y until out_ready
module shift_seq
    import alu_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_dir,
    input  logic [AW-1:0] in_amt,
    input  logic [N-1:0]  in_a,
`ifdef SHIFT_ARITH_EN
    input  logic          in_arith,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_y,
    output logic          busy
);

    state_t        r_state;
    logic [N-1:0]  r_y;
    logic [AW-1:0] r_cnt;
    logic          r_dir;
    logic [AW-1:0] w_eff;
    logic          w_fill;
    logic [N-1:0]  w_step_y;

    // Amounts beyond the operand width saturate; the result is already all fill by then.
    assign w_eff = (in_amt > AW'(N)) ? AW'(N) : in_amt;

`ifdef SHIFT_ARITH_EN
    logic r_arith;
    assign w_fill = (r_dir == DIR_RIGHT) & r_arith & r_y[N-1];
`else
    assign w_fill = 1'b0;
`endif

    shift_step #(.N(N)) u_step (
        .i_dir  (r_dir),
        .i_fill (w_fill),
        .i_a    (r_y),
        .o_y    (w_step_y)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_y     = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_LEFT;
`ifdef SHIFT_ARITH_EN
            r_arith <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_y   <= in_a;
                        r_dir <= in_dir;
                        r_cnt <= w_eff;
`ifdef SHIFT_ARITH_EN
                        r_arith <= in_arith;
`endif
                        r_state <= (w_eff == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_y   <= w_step_y;
                    r_cnt <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, handshake/reset corner sequences, random ops vs. model.
module tb_shift_seq;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_dir = 1'b0;
    logic [AW-1:0] in_amt = '0;
    logic [N-1:0]  in_a = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_y;
    logic          busy;
`ifdef SHIFT_ARITH_EN
    logic          in_arith = 1'b0;
`endif

    shift_seq #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .in_a      (in_a),
`ifdef SHIFT_ARITH_EN
        .in_arith  (in_arith),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0]  a;
        logic          dir;
        logic [AW-1:0] amt;
        logic [N-1:0]  exp_y;
        int            exp_edges;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shifting by eff positions is a plain divide/multiply by 2**eff, with sign fill if requested.
    function automatic int model_y(int a, int dir, int amt, int arith);
        int eff;
        int v;
        eff = (amt > N) ? N : amt;
        if (dir == 1) begin
            v = a >> eff;
            if (arith != 0 && ((a >> (N - 1)) & 1) != 0)
                v = v | ((((1 << eff) - 1) << (N - eff)) & ((1 << N) - 1));
        end else begin
            v = (a << eff) & ((1 << N) - 1);
        end
        return v;
    endfunction

    // Edges after the accept edge until out_valid: zero-amount requests land in DONE on the accept edge.
    function automatic int model_edges(int amt);
        return (amt > N) ? N : amt;
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic dir, input logic [AW-1:0] amt,
                         input logic arith, output logic [N-1:0] y, output int edges);
        @(negedge clk);
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_dir   = dir;
        in_amt   = amt;
`ifdef SHIFT_ARITH_EN
        in_arith = arith;
`else
        if (arith) in_a = a;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = N'($urandom);
        in_dir   = 1'($urandom);
        in_amt   = AW'($urandom);
`ifdef SHIFT_ARITH_EN
        in_arith = 1'($urandom);
`endif
        edges = 0;
        while (!out_valid && edges < 20) begin
            chk("ready_low_in_shift", in_ready, 0);
            chk("busy_in_shift", busy, 1);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        y = out_y;
    endtask

    task automatic release_done();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    task automatic run_vec(input string name, input logic [N-1:0] a, input logic dir,
                           input logic [AW-1:0] amt, input logic arith,
                           input logic [N-1:0] exp_y, input int exp_edges);
        logic [N-1:0] y;
        int edges;
        do_op(a, dir, amt, arith, y, edges);
        chk({name, "_y"}, y, exp_y);
        chk({name, "_latency"}, edges, exp_edges);
        release_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] y;
        int edges;
        logic [N-1:0] ra;
        logic rdir;
        logic [AW-1:0] ramt;
        logic rar;
        int hold;

        vecs[0] = '{4'b1011, 1'b1, 3'd1, 4'b0101, 1};
        vecs[1] = '{4'b0011, 1'b0, 3'd3, 4'b1000, 3};
        vecs[2] = '{4'b1010, 1'b0, 3'd0, 4'b1010, 0};
        vecs[3] = '{4'b1010, 1'b1, 3'd7, 4'b0000, 4};
        vecs[4] = '{4'b1111, 1'b0, 3'd4, 4'b0000, 4};
        vecs[5] = '{4'b1001, 1'b1, 3'd2, 4'b0010, 2};
        vecs[6] = '{4'b0110, 1'b0, 3'd5, 4'b0000, 4};
        vecs[7] = '{4'b1101, 1'b0, 3'd1, 4'b1010, 1};
        vecs[8] = '{4'b1100, 1'b1, 3'd3, 4'b0001, 3};

        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_y", out_y, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);

        // Deassert between edges so the very next rising edge is the first accept opportunity.
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].dir, vecs[i].amt, 1'b0,
                    vecs[i].exp_y, vecs[i].exp_edges);
        end

        do_op(4'b0110, 1'b0, 3'd2, 1'b0, y, edges);
        chk("stall_y_initial", y, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = N'($urandom);
            in_amt   = AW'($urandom);
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_y", out_y, 4'b1000);
            chk("stall_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        release_done();
        run_vec("back_to_back", 4'b0101, 1'b0, 3'd1, 1'b0, 4'b1010, 1);

        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 4'b1111;
        in_dir   = 1'b0;
        in_amt   = 3'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_y", out_y, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after_abort", 4'b0011, 1'b1, 3'd1, 1'b0, 4'b0001, 1);

`ifdef SHIFT_ARITH_EN
        run_vec("arith_on", 4'b1000, 1'b1, 3'd2, 1'b1, 4'b1110, 2);
        run_vec("arith_off", 4'b1000, 1'b1, 3'd2, 1'b0, 4'b0010, 2);
        run_vec("arith_left", 4'b1001, 1'b0, 3'd1, 1'b1, 4'b0010, 1);
`endif

        for (int i = 0; i < 30; i++) begin
            ra   = N'($urandom);
            rdir = 1'($urandom);
            ramt = AW'($urandom_range(0, 7));
`ifdef SHIFT_ARITH_EN
            rar  = 1'($urandom);
`else
            rar  = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(ra, rdir, ramt, rar, y, edges);
            chk($sformatf("rand%0d_y", i), y, model_y(int'(ra), int'(rdir), int'(ramt), int'(rar)));
            chk($sformatf("rand%0d_latency", i), edges, model_edges(int'(ramt)));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk($sformatf("rand%0d_hold", i), out_y, y);
            end
            release_done();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
